// File: rtl/value_checker.sv
// value_checker: arms on start, compares a watched signal against a masked
// goal once per clock, optionally requires the match to hold for a number of
// further cycles, and reports pass / timeout / flake as sticky one-hot flags
// with a single-cycle done pulse.
// Optional feature macro: VALUE_CHECKER_STATS_EN (saturating pass/fail counters).
module value_checker #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] goal,
    input  logic [WIDTH-1:0] mask,
    input  logic [CNT_W-1:0] timeout_cyc,
    input  logic             hold_en,
    input  logic [CNT_W-1:0] hold_cyc,
    input  logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             flake,
    output logic [WIDTH-1:0] fail_val,
    output logic [7:0]       pass_cnt,
    output logic [7:0]       fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] goal_q, goal_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             hen_q, hen_d;
    logic [CNT_W-1:0] hcyc_q, hcyc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             flake_q, flake_d;
    logic [WIDTH-1:0] fail_val_q, fail_val_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             match_s;
    logic [CNT_W-1:0] tmo_eff_s;
    logic             tmo_last_s;
    logic             hold_last_s;

    // Compare and terminal-count decode; a zero timeout behaves as one compare.
    always_comb begin
        match_s     = ((sig ^ goal_q) & mask_q) == {WIDTH{1'b0}};
        tmo_eff_s   = (tmo_q == CNT_ZERO) ? CNT_ONE : tmo_q;
        tmo_last_s  = (cnt_q == (tmo_eff_s - CNT_ONE));
        hold_last_s = (cnt_q == (hcyc_q - CNT_ONE));
    end

    // Next-state, configuration latch, counter and result flag logic.
    always_comb begin
        state_d    = state_q;
        goal_d     = goal_q;
        mask_d     = mask_q;
        tmo_d      = tmo_q;
        hen_d      = hen_q;
        hcyc_d     = hcyc_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        flake_d    = flake_q;
        fail_val_d = fail_val_q;
        if (start) begin
            // start wins in every state: discard any running check
            goal_d    = goal;
            mask_d    = mask;
            tmo_d     = timeout_cyc;
            hen_d     = hold_en;
            hcyc_d    = hold_cyc;
            cnt_d     = CNT_ZERO;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            flake_d   = 1'b0;
            state_d   = ST_WAIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT: begin
                    if (match_s) begin
                        if (!hen_q || (hcyc_q == CNT_ZERO)) begin
                            pass_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = CNT_ZERO;
                            state_d = ST_HOLD;
                        end
                    end else if (tmo_last_s) begin
                        timeout_d  = 1'b1;
                        fail_val_d = sig;
                        state_d    = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!match_s) begin
                        flake_d    = 1'b1;
                        fail_val_d = sig;
                        state_d    = ST_DONE;
                    end else if (hold_last_s) begin
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_WAIT) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            goal_q     <= {WIDTH{1'b0}};
            mask_q     <= {WIDTH{1'b0}};
            tmo_q      <= CNT_ZERO;
            hen_q      <= 1'b0;
            hcyc_q     <= CNT_ZERO;
            cnt_q      <= CNT_ZERO;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            flake_q    <= 1'b0;
            fail_val_q <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            goal_q     <= goal_d;
            mask_q     <= mask_d;
            tmo_q      <= tmo_d;
            hen_q      <= hen_d;
            hcyc_q     <= hcyc_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            flake_q    <= flake_d;
            fail_val_q <= fail_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign flake    = flake_q;
    assign fail_val = fail_val_q;

`ifdef VALUE_CHECKER_STATS_EN
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [7:0] fail_cnt_q, fail_cnt_d;

    // Saturating result statistics, bumped on the edge that enters DONE.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (done_d && !start) begin
            if (pass_d) begin
                pass_cnt_d = (pass_cnt_q == 8'hFF) ? pass_cnt_q : pass_cnt_q + 8'd1;
            end else begin
                fail_cnt_d = (fail_cnt_q == 8'hFF) ? fail_cnt_q : fail_cnt_q + 8'd1;
            end
        end else begin
            pass_cnt_d = pass_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= 8'd0;
            fail_cnt_q <= 8'd0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = 8'd0;
    assign fail_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_value_checker.sv
// Testbench for value_checker: directed table of checks, hand-written
// restart and reset sequences, and randomized checks scored by a
// check-level reference model.
module tb_value_checker;

`ifdef VALUE_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] goal;
    logic [15:0] mask;
    logic [15:0] timeout_cyc;
    logic        hold_en;
    logic [15:0] hold_cyc;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        flake;
    logic [15:0] fail_val;
    logic [7:0]  pass_cnt;
    logic [7:0]  fail_cnt;

    value_checker #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .goal(goal), .mask(mask),
        .timeout_cyc(timeout_cyc), .hold_en(hold_en), .hold_cyc(hold_cyc),
        .sig(sig), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .flake(flake), .fail_val(fail_val), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_pc = 0;
    int exp_fc = 0;
    logic [15:0] sigv [0:31];

    typedef struct {
        logic [15:0] g;
        logic [15:0] m;
        logic [15:0] t;
        logic        he;
        logic [15:0] hc;
        logic [15:0] a;
        int          na;
        logic [15:0] b;
        int          res;   // 0 pass, 1 timeout, 2 flake
        int          n;     // compares until resolution
        logic [15:0] fv;
    } vec_t;

    vec_t tbl [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] flags_of(input int res);
        if (res == 0) return 3'b100;
        else if (res == 1) return 3'b010;
        else return 3'b001;
    endfunction

    function automatic bit is_match(input logic [15:0] s, input logic [15:0] g, input logic [15:0] m);
        return ((s & m) == (g & m));
    endfunction

    // Check-level model: scan the planned sig sequence for the outcome.
    task automatic model(input logic [15:0] g, input logic [15:0] m, input logic [15:0] t,
                         input logic he, input logic [15:0] hc,
                         output int res, output int n, output logic [15:0] fv);
        int limit;
        int k;
        limit = (t == 16'd0) ? 1 : int'(t);
        k = -1;
        for (int i = 0; i < limit; i++) begin
            if (k < 0 && is_match(sigv[i], g, m)) k = i;
        end
        fv = 16'h0000;
        if (k < 0) begin
            res = 1; n = limit; fv = sigv[limit-1];
        end else if (!he || hc == 16'd0) begin
            res = 0; n = k + 1;
        end else begin
            res = 0; n = k + int'(hc) + 1;
            for (int j = int'(hc); j >= 1; j--) begin
                if (!is_match(sigv[k+j], g, m)) begin
                    res = 2; n = k + j + 1; fv = sigv[k+j];
                end
            end
        end
    endtask

    // Arms a check at the next edge and follows it to resolution.
    task automatic run_check(input logic [15:0] g, input logic [15:0] m, input logic [15:0] t,
                             input logic he, input logic [15:0] hc,
                             input int res, input int n, input logic [15:0] fv);
        start = 1'b1; goal = g; mask = m; timeout_cyc = t; hold_en = he; hold_cyc = hc;
        sig = sigv[0];
        @(posedge clk); #1;
        start = 1'b0;
        goal = 16'($urandom); mask = 16'($urandom); timeout_cyc = 16'($urandom_range(0, 3));
        hold_en = 1'($urandom); hold_cyc = 16'($urandom_range(0, 9));
        chk("armed_busy_done", {30'd0, busy, done}, 32'h2);
        chk("armed_flags_clear", {29'd0, pass, timeout, flake}, 32'h0);
        for (int i = 0; i < n; i++) begin
            sig = sigv[i];
            @(posedge clk); #1;
            if (i < n - 1) chk("running_busy_done", {30'd0, busy, done}, 32'h2);
        end
        chk("resolve_busy_done", {30'd0, busy, done}, 32'h1);
        chk("resolve_flags", {29'd0, pass, timeout, flake}, {29'd0, flags_of(res)});
        if (res != 0) chk("fail_val", {16'd0, fail_val}, {16'd0, fv});
        if (res == 0) exp_pc = (exp_pc == 255) ? 255 : exp_pc + 1;
        else          exp_fc = (exp_fc == 255) ? 255 : exp_fc + 1;
        chk("pass_cnt", {24'd0, pass_cnt}, STATS ? exp_pc : 0);
        chk("fail_cnt", {24'd0, fail_cnt}, STATS ? exp_fc : 0);
        @(posedge clk); #1;
        chk("idle_busy_done", {30'd0, busy, done}, 32'h0);
        chk("idle_flags_sticky", {29'd0, pass, timeout, flake}, {29'd0, flags_of(res)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_res, r_n;
        logic [15:0] r_fv, g, m, t, hc;
        logic he;

        tbl[0]  = '{16'h00A5, 16'hFFFF, 16'd10, 1'b0, 16'd0, 16'h00A5, 32, 16'h00A5, 0, 1, 16'h0};
        tbl[1]  = '{16'h1234, 16'hFFFF, 16'd5,  1'b0, 16'd0, 16'h0000, 32, 16'h0000, 1, 5, 16'h0000};
        tbl[2]  = '{16'h00FF, 16'hFFFF, 16'd10, 1'b1, 16'd3, 16'h00FF, 2,  16'h00FE, 2, 3, 16'h00FE};
        tbl[3]  = '{16'h00FF, 16'hFFFF, 16'd10, 1'b1, 16'd3, 16'h00FF, 4,  16'h00FE, 0, 4, 16'h0};
        tbl[4]  = '{16'hAB12, 16'h00FF, 16'd10, 1'b0, 16'd0, 16'hCD12, 32, 16'hCD12, 0, 1, 16'h0};
        tbl[5]  = '{16'h1111, 16'h0000, 16'd10, 1'b0, 16'd0, 16'hBEEF, 32, 16'hBEEF, 0, 1, 16'h0};
        tbl[6]  = '{16'h0001, 16'hFFFF, 16'd0,  1'b0, 16'd0, 16'h0000, 32, 16'h0000, 1, 1, 16'h0000};
        tbl[7]  = '{16'h0005, 16'hFFFF, 16'd10, 1'b1, 16'd0, 16'h0005, 32, 16'h0005, 0, 1, 16'h0};
        tbl[8]  = '{16'h0042, 16'hFFFF, 16'd4,  1'b0, 16'd0, 16'h0000, 3,  16'h0042, 0, 4, 16'h0};
        tbl[9]  = '{16'h0042, 16'hFFFF, 16'd3,  1'b0, 16'd0, 16'h0007, 3,  16'h0042, 1, 3, 16'h0007};
        tbl[10] = '{16'h0F0F, 16'hFFFF, 16'd6,  1'b1, 16'd2, 16'h0000, 2,  16'h0F0F, 0, 5, 16'h0};

        rst_n = 1'b0; start = 1'b0; goal = 16'h0; mask = 16'h0; timeout_cyc = 16'h0;
        hold_en = 1'b0; hold_cyc = 16'h0; sig = 16'h0;
        #2;
        chk("reset_outputs", {busy, done, pass, timeout, flake, fail_val, pass_cnt, fail_cnt}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int v = 0; v < 11; v++) begin
            for (int i = 0; i < 32; i++) sigv[i] = (i < tbl[v].na) ? tbl[v].a : tbl[v].b;
            run_check(tbl[v].g, tbl[v].m, tbl[v].t, tbl[v].he, tbl[v].hc,
                      tbl[v].res, tbl[v].n, tbl[v].fv);
        end

        // Restart during WAIT: first check discarded at its third compare edge
        start = 1'b1; goal = 16'h1234; mask = 16'hFFFF; timeout_cyc = 16'd10;
        hold_en = 1'b0; hold_cyc = 16'd0; sig = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("restart_first_running", {30'd0, busy, done}, 32'h2);
        end
        for (int i = 0; i < 32; i++) sigv[i] = 16'h0000;
        run_check(16'h0000, 16'hFFFF, 16'd10, 1'b0, 16'd0, 0, 1, 16'h0);

        // Randomized checks scored by the model
        for (int c = 0; c < 40; c++) begin
            g = 16'($urandom);
            case ($urandom_range(0, 3))
                0: m = 16'h00FF;
                1: m = 16'($urandom);
                default: m = 16'hFFFF;
            endcase
            t = 16'($urandom_range(0, 8));
            he = 1'($urandom_range(0, 1));
            hc = 16'($urandom_range(0, 5));
            for (int i = 0; i < 32; i++) begin
                case ($urandom_range(0, 3))
                    0, 1: sigv[i] = g;
                    2: sigv[i] = g ^ (16'h1 << $urandom_range(0, 15));
                    default: sigv[i] = 16'($urandom);
                endcase
            end
            model(g, m, t, he, hc, r_res, r_n, r_fv);
            run_check(g, m, t, he, hc, r_res, r_n, r_fv);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset asserted mid-HOLD
        start = 1'b1; goal = 16'h00FF; mask = 16'hFFFF; timeout_cyc = 16'd10;
        hold_en = 1'b1; hold_cyc = 16'd5; sig = 16'h00FF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_busy", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, pass, timeout, flake, fail_val, pass_cnt, fail_cnt}, 32'h0);
        exp_pc = 0; exp_fc = 0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_reset_idle", {28'd0, busy, done, pass, flake}, 32'h0);
        end

        // 300 passes: saturation of pass_cnt
        for (int i = 0; i < 32; i++) sigv[i] = 16'h5A5A;
        for (int p = 0; p < 300; p++) begin
            run_check(16'h0000, 16'h0000, 16'd1, 1'b0, 16'd0, 0, 1, 16'h0);
        end
        chk("pass_cnt_saturated", {24'd0, pass_cnt}, STATS ? 32'd255 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/value_checker.md
VALUE_CHECKER -- requirements
Module: value_checker

Interface
REQ-001 Parameter WIDTH, default 16: width of the watched value, goal and mask.
REQ-002 Parameter CNT_W, default 16: width of the timeout and hold cycle counts.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: arms a new check and latches goal, mask, timeout_cyc, hold_en and hold_cyc.
REQ-006 Port goal, input, WIDTH: target value.
REQ-007 Port mask, input, WIDTH: compare-enable bits; 1 = bit is compared.
REQ-008 Port timeout_cyc, input, CNT_W: maximum compares allowed before a match.
REQ-009 Port hold_en, input, 1: after a match, the value must also hold for hold_cyc further cycles.
REQ-010 Port hold_cyc, input, CNT_W: number of post-match cycles that must also match.
REQ-011 Port sig, input, WIDTH: watched signal.
REQ-012 Port busy, output, 1: a check is in progress.
REQ-013 Port done, output, 1: one-cycle pulse when a check resolves.
REQ-014 Ports pass, timeout, flake, output, 1 each: result flags, one-hot, sticky until the next start.
REQ-015 Port fail_val, output, WIDTH: sig as sampled at the deciding compare of a failed check.
REQ-016 Ports pass_cnt and fail_cnt, output, 8 each: result statistics.

Function
REQ-017 Match definition: (sig & mask) == (goal_latched & mask); a mask of all zeros always matches.
REQ-018 States: IDLE, WAIT, HOLD, DONE.
REQ-019 IDLE: on start, latch the configuration, clear the result flags, clear the counter, and enter WAIT on that same edge.
REQ-020 WAIT: one compare per rising edge, with the first compare on the edge after start; the counter increments on each non-matching compare.
REQ-021 WAIT on a match with hold_en=0 or hold_cyc=0: enter DONE with pass.
REQ-022 WAIT on a match with hold_en=1 and hold_cyc>0: enter HOLD with the counter cleared.
REQ-023 WAIT on a mismatch when the compare count equals max(timeout_cyc,1): enter DONE with timeout and capture fail_val; timeout_cyc=0 behaves as 1.
REQ-024 HOLD: any mismatch enters DONE with flake and captures fail_val; after hold_cyc consecutive matches, enter DONE with pass.
REQ-025 DONE: lasts one cycle with done=1, busy=0 and the result flag set, then returns to IDLE; the flags stay set in IDLE.
REQ-026 busy=1 exactly while in WAIT or HOLD.
REQ-027 Latency: with a match on the first compare and no hold, done is high in the cycle after the edge following the start edge.
REQ-028 start in WAIT, HOLD or DONE restarts the check per REQ-019: the current check is discarded, no done pulse is issued, and no counter updates.
REQ-029 Input changes to goal, mask, timeout_cyc, hold_en or hold_cyc have no effect on a check after its start edge.
REQ-030 The counter never wraps, because resolution occurs at or before max(timeout_cyc,1) or hold_cyc.

Reset
REQ-031 While rst_n=0: state=IDLE; busy, done, pass, timeout and flake are 0; fail_val, pass_cnt, fail_cnt and all latched configuration are 0.
REQ-032 Reset asserted mid-check aborts the check immediately with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-033 Macro VALUE_CHECKER_STATS_EN defined: pass_cnt increments on each pass, fail_cnt on each timeout or flake, both saturating at 255 and updated on entry to DONE.
REQ-034 Macro VALUE_CHECKER_STATS_EN undefined: pass_cnt and fail_cnt are constant 0 and the counter logic is not built; all other behaviour is identical.

Verification
REQ-035 start with goal=16'h00A5, mask=16'hFFFF, timeout_cyc=10, hold_en=0, and sig=16'h00A5 already present -> done two edges after start, pass=1, busy high for 1 cycle.
REQ-036 goal=16'h1234, timeout_cyc=5, sig held at 16'h0000 -> done after 5 compares, timeout=1, fail_val=16'h0000, fail_cnt=1 (STATS_EN).
REQ-037 goal=16'h00FF, hold_en=1, hold_cyc=3, sig=16'h00FF for 2 cycles then 16'h00FE -> flake=1, fail_val=16'h00FE; repeat with 4 matching cycles -> pass=1.
REQ-038 mask=16'h00FF, goal=16'hAB12, sig=16'hCD12 -> pass on the first compare; mask=16'h0000 with any sig -> pass.
REQ-039 start reissued during WAIT at the 3rd compare with a new goal -> no done for the first check, the second resolves normally, counters change once.
REQ-040 rst_n pulsed low mid-HOLD -> all outputs 0 within the same cycle, IDLE until the next start; with STATS_EN, 300 passes -> pass_cnt=255.
